port_ctrl: RTL and testbench
============================

Name: port_ctrl

Overview:
- Sequencer and arbiter in front of the GPIO port block (DDRx/PORTx/PINx register file, ports A/B/C).
- Shares the port block between two requesters: r0 (CPU core) and r1 (debug/auxiliary master). Arbitration is round-robin with a req/gnt/done handshake.
- Executes write, read and read-modify-write (set/clear/toggle) commands.
- Keeps a shadow copy of the PORTx registers, because the port block reads back only the pin mux, not PORTx.

Parameters:
- DATA_W, 8, data width of port registers and command data.
- N_PORTS, 3, number of implemented ports; a sel value >= N_PORTS is invalid.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- r0_req  in  1  requester 0 command request
- r0_op  in  3  requester 0 opcode
- r0_sel  in  2  requester 0 port index (0=A, 1=B, 2=C)
- r0_wdata  in  DATA_W  requester 0 write data or bit mask
- r0_gnt  out  1  requester 0 grant, 1-cycle pulse
- r0_done  out  1  requester 0 completion, 1-cycle pulse
- r1_req, r1_op, r1_sel, r1_wdata, r1_gnt, r1_done  as r0_*, for requester 1
- rsp_rdata  out  DATA_W  read result; valid while either done is high
- rsp_err  out  1  error flag; valid while either done is high
- busy  out  1  high whenever the FSM is not IDLE
- p_dane  out  DATA_W  to port block: data
- p_nr_DDRx  out  2  to port block: DDR index
- p_nr_PORTx  out  2  to port block: PORT index
- p_nr_PINx  out  2  to port block: PIN read index
- p_wr_DDRx  out  1  to port block: DDR write strobe
- p_wr_PORTx  out  1  to port block: PORT write strobe
- p_out  in  DATA_W  from port block: pin mux read data

Behaviour:
- Clock and reset: clk rising edge only. rst is asynchronous, active-high.
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Round-robin pointer = r1, so r0 wins first on a tie.
  - shadow PORT[0..2] = 0.
  - Reset mid-operation aborts the command. No done is issued and no strobe occurs after rst asserts.
- Opcodes:
  - 000 WR_DDR: DDR[sel] <= wdata
  - 001 WR_PORT: PORT[sel] <= wdata
  - 010 RD_PIN: rdata <= PIN[sel]
  - 011 SET: PORT[sel] <= shadow | mask
  - 100 CLR: PORT[sel] <= shadow & ~mask
  - 101 TGL: PORT[sel] <= shadow ^ mask
  - 110, 111: illegal
- FSM states: IDLE, EXEC, SAMPLE, DONE.
- IDLE:
  - If any req is high, select the winner. On a tie, the winner is the requester opposite the pointer.
  - Latch op/sel/wdata/id and pulse the winner's gnt in the next cycle.
  - Go to EXEC and update the pointer to the winner.
- EXEC (1 cycle):
  - sel >= N_PORTS or illegal op: no strobe; err=1; go to DONE.
  - WR_DDR: p_wr_DDRx=1, p_nr_DDRx=sel, p_dane=wdata; go to DONE.
  - WR_PORT/SET/CLR/TGL: p_wr_PORTx=1, p_nr_PORTx=sel, p_dane=computed value; shadow[sel] <= p_dane; go to DONE.
  - RD_PIN: p_nr_PINx=sel; go to SAMPLE.
- SAMPLE: p_nr_PINx held at sel; rsp_rdata <= p_out at the end of the cycle; go to DONE.
- DONE:
  - Pulse the latched requester's done together with rsp_err and rsp_rdata.
  - rsp_rdata = 0 for non-read ops.
  - Go to IDLE.
- Strobes are high only in EXEC, exactly 1 cycle per command. p_dane is 0 outside EXEC; p_nr_DDRx/p_nr_PORTx hold their last value.
- Latency from req sampled in IDLE at edge 0:
  - gnt and strobe in cycle 1.
  - Write/error: done in cycle 2.
  - Read: done in cycle 3.
  - Next arbitration in cycle 3 (write) or cycle 4 (read).
- Handshake rules:
  - A requester holds req/op/sel/wdata stable until its gnt; fields are don't-care after gnt.
  - req still high in the IDLE after done counts as a new command.
  - The losing requester waits; no starvation. With both requests held continuously, grants alternate r0, r1, r0, ...
- Shadow integrity: the shadow is valid only if all PORTx writes go through this block.

Optional Feature:
- Macro: PORT_CTRL_DDR_PROTECT_EN.
- Defined: WR_DDR from r1 is rejected (no p_wr_DDRx; rsp_err=1 in DONE, same timing as the error path). r0 is unaffected.
- Undefined: both requesters may write DDR.

Test Plan:
- Reset then r0 WR_PORT sel=2 wdata=8'hA5 -> r0_gnt in cycle 1; p_wr_PORTx=1, p_nr_PORTx=2, p_dane=A5 in cycle 1; r0_done with rsp_err=0 in cycle 2.
- r0 WR_PORT sel=2 0xA5, then r1 SET mask 0x0F, then r1 TGL mask 0xFF -> p_dane 0xAF, then 0x50; shadow[2]=0x50.
- DDR[0]=0, pins in_out_A driven 0x3C, r1 RD_PIN sel=0 -> r1_done in cycle 3 with rsp_rdata=0x3C; no write strobe at any time.
- r0 and r1 req asserted simultaneously and held for 4 commands -> grant order r0, r1, r0, r1; no cycle has both gnt high.
- r0 WR_DDR sel=3, and r0 op=111 -> no strobe; r0_done with rsp_err=1 in cycle 2. With PORT_CTRL_DDR_PROTECT_EN, r1 WR_DDR sel=1 -> rsp_err=1 and no p_wr_DDRx.
- rst asserted during EXEC of a write -> outputs 0 immediately (asynchronous); no done pulse; shadow cleared; next command arbitrates normally after rst deasserts.

Source files
------------

// File: rtl/port_ctrl_if.sv
// Bundles the requester handshakes and the GPIO port-block signals of port_ctrl.
// The master side is the surrounding system (CPU, debug master and port block); the slave side is the controller.
interface port_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              r0_req;
  logic [2:0]        r0_op;
  logic [1:0]        r0_sel;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_done;

  logic              r1_req;
  logic [2:0]        r1_op;
  logic [1:0]        r1_sel;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_done;

  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  logic [DATA_W-1:0] p_dane;
  logic [1:0]        p_nr_DDRx;
  logic [1:0]        p_nr_PORTx;
  logic [1:0]        p_nr_PINx;
  logic              p_wr_DDRx;
  logic              p_wr_PORTx;
  logic [DATA_W-1:0] p_out;

  modport master (
    output r0_req, r0_op, r0_sel, r0_wdata,
    output r1_req, r1_op, r1_sel, r1_wdata,
    output p_out,
    input  r0_gnt, r0_done, r1_gnt, r1_done,
    input  rsp_rdata, rsp_err, busy,
    input  p_dane, p_nr_DDRx, p_nr_PORTx, p_nr_PINx, p_wr_DDRx, p_wr_PORTx
  );

  modport slave (
    input  r0_req, r0_op, r0_sel, r0_wdata,
    input  r1_req, r1_op, r1_sel, r1_wdata,
    input  p_out,
    output r0_gnt, r0_done, r1_gnt, r1_done,
    output rsp_rdata, rsp_err, busy,
    output p_dane, p_nr_DDRx, p_nr_PORTx, p_nr_PINx, p_wr_DDRx, p_wr_PORTx
  );
endinterface

// File: rtl/port_ctrl.sv
// Round-robin sequencer between two requesters and the GPIO port block, with a PORTx shadow for set/clear/toggle.
// Optional: define PORT_CTRL_DDR_PROTECT_EN to reject WR_DDR commands coming from requester 1.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a request; arbitrates and latches the winner
// S_EXEC   | grant pulse; write strobe or PIN index driven (1 cycle)
// S_SAMPLE | PIN index held, p_out captured at the end of the cycle
// S_DONE   | done pulse with rsp_err / rsp_rdata
module port_ctrl #(
  parameter int DATA_W  = 8,
  parameter int N_PORTS = 3
) (
  input logic       clk,
  input logic       rst,
  port_ctrl_if.slave bus
);

  localparam logic [2:0] OP_WR_DDR  = 3'b000;
  localparam logic [2:0] OP_WR_PORT = 3'b001;
  localparam logic [2:0] OP_RD_PIN  = 3'b010;
  localparam logic [2:0] OP_SET     = 3'b011;
  localparam logic [2:0] OP_CLR     = 3'b100;
  localparam logic [2:0] OP_TGL     = 3'b101;

`ifdef PORT_CTRL_DDR_PROTECT_EN
  localparam bit DDR_PROTECT = 1'b1;
`else
  localparam bit DDR_PROTECT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              id_q;
  logic [2:0]        op_q;
  logic [1:0]        sel_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ptr_q;
  logic [DATA_W-1:0] shadow_q [N_PORTS];
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        nr_ddr_q;
  logic [1:0]        nr_port_q;
  logic [1:0]        nr_pin_q;

  logic              sel_bad, op_bad, prot_bad, cmd_err;
  logic              is_wr_ddr, is_wr_port, is_rd;
  logic [DATA_W-1:0] shadow_cur, port_val;
  logic              latch, win;

  logic              gnt0, gnt1, done0, done1;
  logic              wr_ddr, wr_port;
  logic [DATA_W-1:0] dane;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // Command classification from the latched fields; an error command never strobes.
  always_comb begin
    sel_bad    = (int'(sel_q) >= N_PORTS);
    op_bad     = (op_q > OP_TGL);
    prot_bad   = DDR_PROTECT && id_q && (op_q == OP_WR_DDR);
    cmd_err    = sel_bad || op_bad || prot_bad;
    is_wr_ddr  = !cmd_err && (op_q == OP_WR_DDR);
    is_rd      = !cmd_err && (op_q == OP_RD_PIN);
    is_wr_port = !cmd_err && ((op_q == OP_WR_PORT) || (op_q == OP_SET) ||
                              (op_q == OP_CLR) || (op_q == OP_TGL));
  end

  always_comb begin
    shadow_cur = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (int'(sel_q) == i) shadow_cur = shadow_q[i];
    end
  end

  always_comb begin
    port_val = wdata_q;
    case (op_q)
      OP_SET:  port_val = shadow_cur | wdata_q;
      OP_CLR:  port_val = shadow_cur & ~wdata_q;
      OP_TGL:  port_val = shadow_cur ^ wdata_q;
      default: port_val = wdata_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    win       = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    wr_ddr    = 1'b0;
    wr_port   = 1'b0;
    dane      = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          latch   = 1'b1;
          // On a tie the requester opposite the pointer wins.
          win     = (bus.r0_req && bus.r1_req) ? ~ptr_q : bus.r1_req;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        gnt0    = ~id_q;
        gnt1    = id_q;
        wr_ddr  = is_wr_ddr;
        wr_port = is_wr_port;
        if (is_wr_ddr)       dane = wdata_q;
        else if (is_wr_port) dane = port_val;
        state_d = is_rd ? S_SAMPLE : S_DONE;
      end
      S_SAMPLE: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        done0     = ~id_q;
        done1     = id_q;
        rsp_err   = cmd_err;
        rsp_rdata = is_rd ? rdata_q : '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q      <= 1'b0;
      op_q      <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      ptr_q     <= 1'b1;
      rdata_q   <= '0;
      nr_ddr_q  <= '0;
      nr_port_q <= '0;
      nr_pin_q  <= '0;
      for (int i = 0; i < N_PORTS; i++) shadow_q[i] <= '0;
    end else begin
      if (latch) begin
        id_q    <= win;
        ptr_q   <= win;
        op_q    <= win ? bus.r1_op    : bus.r0_op;
        sel_q   <= win ? bus.r1_sel   : bus.r0_sel;
        wdata_q <= win ? bus.r1_wdata : bus.r0_wdata;
      end
      if (state_q == S_EXEC) begin
        if (is_wr_ddr) nr_ddr_q <= sel_q;
        if (is_wr_port) begin
          nr_port_q <= sel_q;
          for (int i = 0; i < N_PORTS; i++) begin
            if (int'(sel_q) == i) shadow_q[i] <= port_val;
          end
        end
        if (is_rd) nr_pin_q <= sel_q;
      end
      if (state_q == S_SAMPLE) rdata_q <= bus.p_out;
    end
  end

  // Indices follow the active command in EXEC and hold their last value otherwise.
  assign bus.p_nr_DDRx  = (state_q == S_EXEC && is_wr_ddr)  ? sel_q : nr_ddr_q;
  assign bus.p_nr_PORTx = (state_q == S_EXEC && is_wr_port) ? sel_q : nr_port_q;
  assign bus.p_nr_PINx  = (state_q == S_EXEC && is_rd)      ? sel_q : nr_pin_q;
  assign bus.p_wr_DDRx  = wr_ddr;
  assign bus.p_wr_PORTx = wr_port;
  assign bus.p_dane     = dane;
  assign bus.r0_gnt     = gnt0;
  assign bus.r1_gnt     = gnt1;
  assign bus.r0_done    = done0;
  assign bus.r1_done    = done1;
  assign bus.rsp_rdata  = rsp_rdata;
  assign bus.rsp_err    = rsp_err;
  assign bus.busy       = (state_q != S_IDLE);

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
  a_strobe_excl : assert property (@(posedge clk) disable iff (rst) !(wr_ddr && wr_port));
  a_strobe_exec : assert property (@(posedge clk) disable iff (rst)
                                   (wr_ddr || wr_port) |-> (state_q == S_EXEC));

endmodule

// File: tb/tb_port_ctrl.sv
// Randomized scoreboard bench for port_ctrl: a command-level model predicts grant order, strobes and responses.
module tb_port_ctrl;
  localparam int DATA_W = 8;
`ifdef PORT_CTRL_DDR_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  typedef struct {
    logic [2:0] op;
    logic [1:0] sel;
    logic [7:0] wdata;
  } cmd_t;
  typedef struct {
    bit         id;
    bit         err;
    logic [7:0] rdata;
    int         lat;
  } done_t;
  typedef struct {
    bit         is_ddr;
    logic [1:0] sel;
    logic [7:0] dane;
  } strb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  port_ctrl_if #(.DATA_W(DATA_W)) bus();
  port_ctrl #(.DATA_W(DATA_W), .N_PORTS(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] pin_val [4];
  assign bus.p_out = pin_val[bus.p_nr_PINx];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    gnt_cyc [2];
  bit    first_winner;
  bit    m_ptr = 1'b1;
  logic [7:0] m_shadow [4];
  bit    exp_gnt [$];
  done_t exp_done [$];
  strb_t exp_strb [$];
  cmd_t  scn0 [$];
  cmd_t  scn1 [$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not matched by model (t=%0t)", name, $time);
  endfunction

  function automatic cmd_t mk(input logic [2:0] op, input logic [1:0] sel, input logic [7:0] w);
    cmd_t c;
    c.op = op; c.sel = sel; c.wdata = w;
    return c;
  endfunction

  // Command-level reference: what one granted command must do to the port block and response.
  function automatic void model_cmd(input bit id, input cmd_t c);
    done_t d; strb_t s; logic [7:0] v;
    d.id = id; d.err = 1'b0; d.rdata = 8'h00; d.lat = 1;
    if (c.sel > 2 || c.op > 5 || (PROT && id && c.op == 3'd0)) begin
      d.err = 1'b1;
    end else if (c.op == 3'd2) begin
      d.rdata = pin_val[c.sel];
      d.lat = 2;
    end else begin
      s.is_ddr = (c.op == 3'd0);
      s.sel = c.sel;
      case (c.op)
        3'd3:    v = m_shadow[c.sel] | c.wdata;
        3'd4:    v = m_shadow[c.sel] & ~c.wdata;
        3'd5:    v = m_shadow[c.sel] ^ c.wdata;
        default: v = c.wdata;
      endcase
      if (!s.is_ddr) m_shadow[c.sel] = v;
      s.dane = v;
      exp_strb.push_back(s);
    end
    exp_done.push_back(d);
  endfunction

  task automatic set_req(input bit id, input logic r, input cmd_t c);
    if (!id) begin
      bus.r0_req = r; bus.r0_op = c.op; bus.r0_sel = c.sel; bus.r0_wdata = c.wdata;
    end else begin
      bus.r1_req = r; bus.r1_op = c.op; bus.r1_sel = c.sel; bus.r1_wdata = c.wdata;
    end
  endtask

  task automatic drive(input bit id);
    int cnt;
    int n;
    logic g;
    cnt = id ? scn1.size() : scn0.size();
    for (int i = 0; i < cnt; i++) begin
      cmd_t c;
      c = id ? scn1[i] : scn0[i];
      set_req(id, 1'b1, c);
      n = 0;
      do begin
        @(negedge clk);
        n++;
        g = id ? bus.r1_gnt : bus.r0_gnt;
      end while (!g && n < 100);
      if (!g) begin
        miss(id ? "gnt_timeout_r1" : "gnt_timeout_r0");
        set_req(id, 1'b0, c);
        return;
      end
      if (i == 0 && id == first_winner) chk("first_gnt_latency", n, 1);
      set_req(id, 1'b0, c);
    end
  endtask

  task automatic run_scn();
    int i0 = 0;
    int i1 = 0;
    int n = 0;
    bit w;
    while (i0 < scn0.size() || i1 < scn1.size()) begin
      if (i0 < scn0.size() && i1 < scn1.size()) w = !m_ptr;
      else w = (i1 < scn1.size());
      exp_gnt.push_back(w);
      if (w) model_cmd(1'b1, scn1[i1++]);
      else   model_cmd(1'b0, scn0[i0++]);
      m_ptr = w;
    end
    first_winner = exp_gnt[0];
    @(negedge clk);
    fork
      begin if (scn0.size() != 0) drive(1'b0); end
      begin if (scn1.size() != 0) drive(1'b1); end
    join
    while (exp_done.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_done.size() != 0) begin
      miss("done_timeout");
      exp_done.delete();
    end
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("gnt_queue_drained", exp_gnt.size(), 0);
    chk("strobe_queue_drained", exp_strb.size(), 0);
    exp_gnt.delete();
    exp_strb.delete();
    scn0.delete();
    scn1.delete();
  endtask

  always @(negedge clk) begin
    bit    gid;
    strb_t s;
    done_t d;
    cyc++;
    if (!rst) begin
      if (bus.r0_gnt || bus.r1_gnt) begin
        chk("gnt_onehot", {31'd0, bus.r0_gnt & bus.r1_gnt}, 0);
        chk("busy_in_exec", bus.busy, 1);
        gid = bus.r1_gnt;
        gnt_cyc[gid] = cyc;
        if (exp_gnt.size() == 0) miss("gnt_unexpected");
        else chk("gnt_order", gid, exp_gnt.pop_front());
      end
      if (bus.p_wr_DDRx || bus.p_wr_PORTx) begin
        chk("strobe_excl", {31'd0, bus.p_wr_DDRx & bus.p_wr_PORTx}, 0);
        chk("strobe_with_gnt", bus.r0_gnt | bus.r1_gnt, 1);
        if (exp_strb.size() == 0) miss("strobe_unexpected");
        else begin
          s = exp_strb.pop_front();
          chk("strobe_kind", bus.p_wr_DDRx, s.is_ddr);
          chk("strobe_sel", bus.p_wr_DDRx ? bus.p_nr_DDRx : bus.p_nr_PORTx, s.sel);
          chk("strobe_dane", bus.p_dane, s.dane);
        end
      end else if (!(bus.r0_gnt || bus.r1_gnt)) begin
        chk("dane_idle", bus.p_dane, 0);
      end
      if (bus.r0_done || bus.r1_done) begin
        chk("done_onehot", {31'd0, bus.r0_done & bus.r1_done}, 0);
        gid = bus.r1_done;
        if (exp_done.size() == 0) miss("done_unexpected");
        else begin
          d = exp_done.pop_front();
          chk("done_id", gid, d.id);
          chk("done_err", bus.rsp_err, d.err);
          chk("done_rdata", bus.rsp_rdata, d.rdata);
          chk("done_latency", cyc - gnt_cyc[gid], d.lat);
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t z;
    z = mk(3'd0, 2'd0, 8'h00);
    set_req(1'b0, 1'b0, z);
    set_req(1'b1, 1'b0, z);
    for (int i = 0; i < 4; i++) begin
      pin_val[i] = 8'h00;
      m_shadow[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    chk("rst_gnt_done", {bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done}, 0);
    chk("rst_strobes_busy", {bus.p_wr_DDRx, bus.p_wr_PORTx, bus.busy}, 0);
    chk("rst_dane", bus.p_dane, 0);
    chk("rst_idx", {bus.p_nr_DDRx, bus.p_nr_PORTx, bus.p_nr_PINx}, 0);
    chk("rst_rsp", {bus.rsp_err, bus.rsp_rdata}, 0);
    rst = 1'b0;

    // Single write, then set/toggle through the shadow, then a zero-mask set exposes the shadow.
    scn0.push_back(mk(3'd1, 2'd2, 8'hA5));
    run_scn();
    scn1.push_back(mk(3'd3, 2'd2, 8'h0F));
    scn1.push_back(mk(3'd5, 2'd2, 8'hFF));
    scn1.push_back(mk(3'd3, 2'd2, 8'h00));
    run_scn();

    pin_val[0] = 8'h3C; pin_val[1] = 8'h11; pin_val[2] = 8'h22; pin_val[3] = 8'h33;
    scn1.push_back(mk(3'd2, 2'd0, 8'h00));
    run_scn();

    // Both requesters held for two commands each: grants alternate.
    scn0.push_back(mk(3'd1, 2'd0, 8'h12));
    scn0.push_back(mk(3'd4, 2'd0, 8'h02));
    scn1.push_back(mk(3'd0, 2'd1, 8'hF0));
    scn1.push_back(mk(3'd1, 2'd1, 8'h5A));
    run_scn();

    scn0.push_back(mk(3'd0, 2'd3, 8'hFF));
    scn0.push_back(mk(3'd7, 2'd0, 8'h01));
    scn0.push_back(mk(3'd2, 2'd3, 8'h00));
    run_scn();
    scn1.push_back(mk(3'd0, 2'd1, 8'hC3));
    scn0.push_back(mk(3'd0, 2'd2, 8'h3C));
    run_scn();

    // Reset during EXEC of a write.
    @(negedge clk);
    begin
      strb_t s;
      s.is_ddr = 1'b0; s.sel = 2'd1; s.dane = 8'h77;
      exp_gnt.push_back(1'b0);
      exp_strb.push_back(s);
    end
    set_req(1'b0, 1'b1, mk(3'd1, 2'd1, 8'h77));
    @(negedge clk);
    chk("rst_pre_gnt", bus.r0_gnt, 1);
    set_req(1'b0, 1'b0, z);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_strobe", bus.p_wr_PORTx, 0);
    chk("rst_async_gnt", bus.r0_gnt, 0);
    chk("rst_async_busy", bus.busy, 0);
    chk("rst_async_dane", bus.p_dane, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", bus.r0_done | bus.r1_done, 0);
    end
    rst = 1'b0;
    m_ptr = 1'b1;
    for (int i = 0; i < 4; i++) m_shadow[i] = 8'h00;
    exp_gnt.delete(); exp_strb.delete(); exp_done.delete();
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", {bus.busy, bus.r0_done, bus.r1_done}, 0);
    end
    scn0.push_back(mk(3'd3, 2'd1, 8'h01));
    scn1.push_back(mk(3'd3, 2'd1, 8'h02));
    run_scn();

    for (int k = 0; k < 40; k++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int i = 0; i < 4; i++) pin_val[i] = 8'($urandom);
      for (int i = 0; i < n0 + n1; i++) begin
        cmd_t c;
        c.op    = 3'($urandom_range(0, 7));
        c.sel   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        c.wdata = 8'($urandom);
        if (i < n0) scn0.push_back(c);
        else        scn1.push_back(c);
      end
      run_scn();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
